// File: rtl/sar_conv_scheduler_if.sv
// Signal bundle between the conversion scheduler, its requesters and the SAR ADC FSM.
// Ports: requester side (req_i, ack_o, result_o), analog/SAR side
//   (ch_sel_o, analog_ready_i, trigger_o, conv_done_i, conv_result_i,
//   interrupt_clear_o), status (busy_o, timeout_o).
//   master = scheduler, slave = environment (requesters + SAR FSM).

interface sar_conv_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] req_i;
    logic [NUM_CH-1:0] ack_o;
    logic [DATA_W-1:0] result_o;
    logic [CH_W-1:0]   ch_sel_o;
    logic              analog_ready_i;
    logic              trigger_o;
    logic              conv_done_i;
    logic [DATA_W-1:0] conv_result_i;
    logic              interrupt_clear_o;
    logic              busy_o;
    logic              timeout_o;

    modport master (
        input  req_i,
        input  analog_ready_i,
        input  conv_done_i,
        input  conv_result_i,
        output ack_o,
        output result_o,
        output ch_sel_o,
        output trigger_o,
        output interrupt_clear_o,
        output busy_o,
        output timeout_o
    );

    modport slave (
        output req_i,
        output analog_ready_i,
        output conv_done_i,
        output conv_result_i,
        input  ack_o,
        input  result_o,
        input  ch_sel_o,
        input  trigger_o,
        input  interrupt_clear_o,
        input  busy_o,
        input  timeout_o
    );
endinterface

// File: rtl/sar_conv_scheduler.sv
// Round-robin conversion scheduler in front of a SAR ADC control FSM.
// Ports: clk_i, rst_i (async, active-high), bus (sar_conv_scheduler_if.master).
// Optional: define SAR_SCHED_TIMEOUT_EN to bound time in CONVERT to
//   TIMEOUT_CYCLES; otherwise CONVERT waits forever and timeout_o is 0.

module sar_conv_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sar_conv_scheduler_if.master bus
);
    localparam int CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $fatal(1, "sar_conv_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        TRIG,
        CONVERT,
        CLEAR,
        ACK
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   rr_next;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_vld;
    logic [DATA_W-1:0] result_q, result_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic              trig_q, trig_d;
    logic              clr_q, clr_d;
    logic              busy_q, busy_d;
    logic              to_q, to_d;
    logic              to_seen_q, to_seen_d;
    logic              to_hit;

    // First requester at or after rr_q. Scanning offsets from high to low
    // lets the smallest offset overwrite the rest.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] sel;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        sel       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            sel = CH_W'(idx);
            if (bus.req_i[sel]) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end
    end

    // Explicit wrap so unused codes never appear for non-power-of-two NUM_CH.
    assign rr_next = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);

`ifdef SAR_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // to_cnt_q counts completed CONVERT cycles; the timeout fires in the
    // cycle whose increment would reach TIMEOUT_CYCLES, so at most
    // TIMEOUT_CYCLES cycles are spent in CONVERT.
    assign to_hit = (state_q == CONVERT) &&
                    (int'(to_cnt_q) + 1 == TIMEOUT_CYCLES);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else if (state_q != CONVERT) begin
            to_cnt_q <= '0;
        end else if (!to_hit) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        to_seen_d = to_seen_q;
        ack_d     = '0;
        to_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d   = WAIT_READY;
                    to_seen_d = 1'b0;
                end
            end
            WAIT_READY: begin
                if (bus.analog_ready_i) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                state_d = CONVERT;
            end
            CONVERT: begin
                // A real completion takes priority over a coincident timeout.
                if (bus.conv_done_i) begin
                    result_d = bus.conv_result_i;
                    state_d  = CLEAR;
                end else if (to_hit) begin
                    result_d  = '1;
                    to_seen_d = 1'b1;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        trig_d = (state_d == TRIG);
        clr_d  = (state_d == CLEAR);
        busy_d = (state_d != IDLE);
        if (state_d == ACK) begin
            ack_d[ch_q] = 1'b1;
            to_d        = to_seen_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            ch_q      <= '0;
            result_q  <= '0;
            ack_q     <= '0;
            trig_q    <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            to_q      <= 1'b0;
            to_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            ack_q     <= ack_d;
            trig_q    <= trig_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            to_q      <= to_d;
            to_seen_q <= to_seen_d;
            if (state_q == IDLE && grant_vld) begin
                ch_q <= grant_idx;
            end
            if (state_q == ACK) begin
                rr_q <= rr_next;
            end
        end
    end

    assign bus.ack_o             = ack_q;
    assign bus.result_o          = result_q;
    assign bus.ch_sel_o          = ch_q;
    assign bus.trigger_o         = trig_q;
    assign bus.interrupt_clear_o = clr_q;
    assign bus.busy_o            = busy_q;
    assign bus.timeout_o         = to_q;

endmodule
